// File: rtl/pll_reconfig_master.sv
// pll_reconfig_master
// Avalon-MM master that reprograms a Cyclone V fractional PLL through the
// PLL reconfiguration core: mode, M, N and NUM_C counter writes, start,
// status polling, a lock guard interval and a wait for pll_locked.
// Optional feature macro: PLL_RECONFIG_LOCK_TIMEOUT_EN enables a lock
// timeout that sets the sticky cfg_err flag; without it cfg_err is tied 0.
// LOCK_GUARD must be at least 1.

module pll_reconfig_master #(
  parameter int NUM_C        = 6,
  parameter int LOCK_GUARD   = 16,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [17:0]           cfg_m,
  input  logic [17:0]           cfg_n,
  input  logic [NUM_C*18-1:0]   cfg_c,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [5:0]            mgmt_address,
  output logic                  mgmt_write,
  output logic                  mgmt_read,
  output logic [31:0]           mgmt_writedata,
  input  logic [31:0]           mgmt_readdata,
  input  logic                  mgmt_waitrequest,
  input  logic                  pll_locked
);

  localparam int CW = NUM_C * 18;
  localparam int GW = (LOCK_GUARD > 1) ? $clog2(LOCK_GUARD) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(LOCK_GUARD - 1);
  localparam logic [4:0]    K_LAST     = 5'(NUM_C - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_WR_M, S_WR_N, S_WR_C,
    S_START, S_POLL, S_GUARD, S_LOCK_WAIT, S_DONE
  } state_t;

  state_t          state;
  logic [17:0]     m_q;
  logic [17:0]     n_q;
  logic [CW-1:0]   c_sr;
  logic [CW-1:0]   c_next;
  logic [4:0]      k;
  logic [GW-1:0]   guard_cnt;

  // Only the done bit of the status register matters.
  logic unused_readdata;
  assign unused_readdata = ^mgmt_readdata[31:1];

  // The C words are consumed lowest counter first by shifting the latched copy.
  assign c_next = c_sr >> 18;

`ifdef PLL_RECONFIG_LOCK_TIMEOUT_EN
  localparam logic [19:0] LOCK_LAST = 20'(LOCK_TIMEOUT - 1);
  logic [19:0] lock_cnt;
  logic        err_q;
  assign cfg_err = err_q;
`else
  localparam int unused_lock_timeout = LOCK_TIMEOUT;
  assign cfg_err = 1'b0;
`endif

  // Sequencer: every output is a register loaded with the values for the next
  // bus cycle; a stalled transaction simply leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      m_q            <= '0;
      n_q            <= '0;
      c_sr           <= '0;
      k              <= '0;
      guard_cnt      <= '0;
      cfg_busy       <= 1'b0;
      cfg_done       <= 1'b0;
      mgmt_address   <= '0;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
      mgmt_writedata <= '0;
`ifdef PLL_RECONFIG_LOCK_TIMEOUT_EN
      lock_cnt       <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            m_q            <= cfg_m;
            n_q            <= cfg_n;
            c_sr           <= cfg_c;
            k              <= '0;
            cfg_busy       <= 1'b1;
            mgmt_write     <= 1'b1;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd1;
            state          <= S_MODE;
`ifdef PLL_RECONFIG_LOCK_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
          end
        end
        S_MODE: begin
          if (!mgmt_waitrequest) begin
            mgmt_address   <= 6'd4;
            mgmt_writedata <= {14'b0, m_q};
            state          <= S_WR_M;
          end
        end
        S_WR_M: begin
          if (!mgmt_waitrequest) begin
            mgmt_address   <= 6'd3;
            mgmt_writedata <= {14'b0, n_q};
            state          <= S_WR_N;
          end
        end
        S_WR_N: begin
          if (!mgmt_waitrequest) begin
            k              <= '0;
            mgmt_address   <= 6'd5;
            mgmt_writedata <= {9'b0, 5'd0, c_sr[17:0]};
            state          <= S_WR_C;
          end
        end
        S_WR_C: begin
          if (!mgmt_waitrequest) begin
            if (k == K_LAST) begin
              mgmt_address   <= 6'd2;
              mgmt_writedata <= 32'd0;
              state          <= S_START;
            end else begin
              k              <= k + 5'd1;
              c_sr           <= c_next;
              mgmt_writedata <= {9'b0, k + 5'd1, c_next[17:0]};
            end
          end
        end
        S_START: begin
          if (!mgmt_waitrequest) begin
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b1;
            mgmt_address   <= 6'd1;
            mgmt_writedata <= 32'd0;
            state          <= S_POLL;
          end
        end
        S_POLL: begin
          if (!mgmt_waitrequest && mgmt_readdata[0]) begin
            mgmt_read    <= 1'b0;
            mgmt_address <= 6'd0;
            guard_cnt    <= '0;
            state        <= S_GUARD;
          end
        end
        S_GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state <= S_LOCK_WAIT;
`ifdef PLL_RECONFIG_LOCK_TIMEOUT_EN
            lock_cnt <= '0;
`endif
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        S_LOCK_WAIT: begin
          if (pll_locked) begin
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            state    <= S_DONE;
          end
`ifdef PLL_RECONFIG_LOCK_TIMEOUT_EN
          else if (lock_cnt == LOCK_LAST) begin
            err_q    <= 1'b1;
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            state    <= S_DONE;
          end else begin
            lock_cnt <= lock_cnt + 20'd1;
          end
`endif
        end
        S_DONE: begin
          cfg_done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_master.sv
// Testbench for pll_reconfig_master: drives randomized configurations and
// bus behaviour, and compares against a transaction-level reference model.
// Define PLL_RECONFIG_LOCK_TIMEOUT_EN to also exercise the lock timeout.

module tb_pll_reconfig_master;

  localparam int NUM_C  = 2;
  localparam int LG     = 4;
  localparam int LT     = 100;
  localparam int CW     = NUM_C * 18;
  localparam int BUDGET = 2000;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start;
  logic [17:0]     cfg_m;
  logic [17:0]     cfg_n;
  logic [CW-1:0]   cfg_c;
  logic            cfg_busy;
  logic            cfg_done;
  logic            cfg_err;
  logic [5:0]      mgmt_address;
  logic            mgmt_write;
  logic            mgmt_read;
  logic [31:0]     mgmt_writedata;
  logic [31:0]     mgmt_readdata;
  logic            mgmt_waitrequest;
  logic            pll_locked;

  pll_reconfig_master #(.NUM_C(NUM_C), .LOCK_GUARD(LG), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .cfg_c(cfg_c), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t got_q[$];
  txn_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int stall_pct, stall_addr, stall_left, zeros_left, lock_d;
  bit lock_never, glitch_start;

  int   c0, poll_ok_cyc, done_cyc, stalls, busy_cycles, done_cycles, proto_errs, hold_cnt;
  bit   prev_stalled;
  logic [39:0] prev_bus;

  // One clock of bus-slave and PLL behaviour, sampled mid-cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (prev_stalled && {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata} !== prev_bus)
      proto_errs++;
    if (mgmt_write && mgmt_read) proto_errs++;
    if (!mgmt_write && !mgmt_read && (mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0))
      proto_errs++;
    cfg_start = 1'b0;
    cfg_m = 18'($urandom());
    cfg_n = 18'($urandom());
    cfg_c = CW'({$urandom(), $urandom()});
    if (glitch_start && mgmt_write && mgmt_address == 6'd5) begin
      cfg_start    = 1'b1;
      glitch_start = 1'b0;
    end
    mgmt_waitrequest = 1'b0;
    if ((mgmt_write || mgmt_read) && stall_left > 0 && mgmt_address == stall_addr) begin
      mgmt_waitrequest = 1'b1;
      stall_left--;
    end else if ($urandom_range(99) < stall_pct) begin
      mgmt_waitrequest = 1'b1;
    end
    mgmt_readdata    = $urandom();
    mgmt_readdata[0] = (zeros_left == 0);
    if ((mgmt_write || mgmt_read) && mgmt_waitrequest) stalls++;
    if (mgmt_write && mgmt_address == 6'd3) hold_cnt++;
    if (mgmt_write && !mgmt_waitrequest)
      got_q.push_back({1'b1, mgmt_address, mgmt_writedata});
    if (mgmt_read && !mgmt_waitrequest) begin
      got_q.push_back({1'b0, mgmt_address, 32'd0});
      if (zeros_left == 0) poll_ok_cyc = cyc;
      else zeros_left--;
    end
    if (poll_ok_cyc < 0) pll_locked = 1'b0;
    else if (cyc - poll_ok_cyc <= LG) pll_locked = !lock_never;
    else pll_locked = !lock_never && (cyc - poll_ok_cyc > LG + lock_d);
    if (cfg_busy) busy_cycles++;
    if (cfg_done) begin
      done_cycles++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    prev_stalled = (mgmt_write || mgmt_read) && mgmt_waitrequest;
    prev_bus     = {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
  endtask

  // Reference model: the ordered list of bus transactions a request produces.
  function automatic void build_expected(input logic [17:0] m, input logic [17:0] n,
                                         input logic [CW-1:0] c, input int reads);
    exp_q.delete();
    exp_q.push_back({1'b1, 6'd0, 32'd1});
    exp_q.push_back({1'b1, 6'd4, 14'b0, m});
    exp_q.push_back({1'b1, 6'd3, 14'b0, n});
    for (int kk = 0; kk < NUM_C; kk++)
      exp_q.push_back({1'b1, 6'd5, 9'b0, 5'(kk), c[18*kk +: 18]});
    exp_q.push_back({1'b1, 6'd2, 32'd0});
    for (int r = 0; r < reads; r++)
      exp_q.push_back({1'b0, 6'd1, 32'd0});
  endfunction

  // Issue one request and observe until cfg_done (or the budget runs out).
  task automatic run_cfg(input logic [17:0] m, input logic [17:0] n, input logic [CW-1:0] c);
    got_q.delete();
    stalls = 0; busy_cycles = 0; done_cycles = 0; proto_errs = 0; hold_cnt = 0;
    done_cyc = -1; poll_ok_cyc = -1; prev_stalled = 0;
    cfg_m = m; cfg_n = n; cfg_c = c; cfg_start = 1'b1;
    c0 = cyc + 1;
    for (int i = 0; i < BUDGET && done_cyc < 0; i++) step();
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({cfg_busy, cfg_done, cfg_err, mgmt_address, mgmt_write, mgmt_read, mgmt_writedata} !== '0)
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {cfg_busy, cfg_done, cfg_err, mgmt_address, mgmt_write, mgmt_read, mgmt_writedata});
    else n_pass++;
    rst = 1'b0;
    step();
    step();
    n_checks++;
    if ({cfg_busy, mgmt_write, mgmt_read} !== 3'b000)
      $display("[TB] FAIL idle_after_reset: got %b expected 000", {cfg_busy, mgmt_write, mgmt_read});
    else n_pass++;
  endtask

  task automatic test_directed();
    stall_pct = 0; stall_addr = -1; stall_left = 0; zeros_left = 0; lock_d = 0;
    run_cfg(18'h01212, 18'h20302, {18'h00F0F, 18'h01E1E});
    build_expected(18'h01212, 18'h20302, {18'h00F0F, 18'h01E1E}, 1);
    n_checks++;
    if (got_q.size() !== exp_q.size())
      $display("[TB] FAIL directed_txn_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("[TB] FAIL directed_txn%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc !== c0 + 6 + NUM_C + LG)
      $display("[TB] FAIL directed_latency: got %0d expected %0d", done_cyc - c0, 6 + NUM_C + LG);
    else n_pass++;
    n_checks++;
    if (done_cycles !== 1 || busy_cycles !== done_cyc - c0)
      $display("[TB] FAIL directed_done_busy: got done=%0d busy=%0d expected done=1 busy=%0d",
               done_cycles, busy_cycles, done_cyc - c0);
    else n_pass++;
    n_checks++;
    if (proto_errs !== 0 || cfg_err !== 1'b0)
      $display("[TB] FAIL directed_protocol: got errs=%0d cfg_err=%b expected 0/0", proto_errs, cfg_err);
    else n_pass++;
  endtask

  task automatic test_waitrequest();
    stall_pct = 0; stall_addr = 3; stall_left = 3; zeros_left = 0; lock_d = 0;
    run_cfg(18'h01212, 18'h20302, {18'h00F0F, 18'h01E1E});
    build_expected(18'h01212, 18'h20302, {18'h00F0F, 18'h01E1E}, 1);
    n_checks++;
    if (got_q.size() !== exp_q.size())
      $display("[TB] FAIL wait_txn_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("[TB] FAIL wait_txn%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (hold_cnt !== 4)
      $display("[TB] FAIL wait_hold_cycles: got %0d expected 4", hold_cnt);
    else n_pass++;
    n_checks++;
    if (done_cyc !== c0 + 6 + NUM_C + LG + 3 || proto_errs !== 0)
      $display("[TB] FAIL wait_latency: got %0d errs=%0d expected %0d errs=0",
               done_cyc - c0, proto_errs, 9 + NUM_C + LG);
    else n_pass++;
    stall_addr = -1;
  endtask

  task automatic test_poll_retry();
    int reads;
    stall_pct = 0; zeros_left = 2; lock_d = 0;
    run_cfg(18'h3ABCD, 18'h00101, {18'h12345, 18'h2FEDC});
    reads = 0;
    foreach (got_q[i]) if (!got_q[i].is_wr) reads++;
    n_checks++;
    if (reads !== 3)
      $display("[TB] FAIL poll_reads: got %0d expected 3", reads);
    else n_pass++;
    n_checks++;
    if (done_cyc !== c0 + 8 + NUM_C + LG)
      $display("[TB] FAIL poll_latency: got %0d expected %0d", done_cyc - c0, 8 + NUM_C + LG);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    logic [17:0] m, n;
    logic [CW-1:0] c;
    m = 18'($urandom()); n = 18'($urandom()); c = CW'({$urandom(), $urandom()});
    stall_pct = 20; zeros_left = 1; lock_d = 2; glitch_start = 1'b1;
    run_cfg(m, n, c);
    build_expected(m, n, c, 2);
    n_checks++;
    if (got_q.size() !== exp_q.size())
      $display("[TB] FAIL glitch_txn_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("[TB] FAIL glitch_txn%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cycles !== 1 || cfg_busy !== 1'b0)
      $display("[TB] FAIL glitch_single_run: got done=%0d busy=%b expected 1/0", done_cycles, cfg_busy);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [17:0] m, n;
    logic [CW-1:0] c;
    int zeros, exp_lat;
    for (int it = 0; it < 8; it++) begin
      m = 18'($urandom()); n = 18'($urandom()); c = CW'({$urandom(), $urandom()});
      stall_pct = $urandom_range(0, 40);
      zeros = $urandom_range(0, 3);
      zeros_left = zeros;
      lock_d = $urandom_range(0, 5);
      run_cfg(m, n, c);
      build_expected(m, n, c, zeros + 1);
      exp_lat = 6 + NUM_C + LG + stalls + zeros + lock_d;
      n_checks++;
      if (got_q.size() !== exp_q.size())
        $display("[TB] FAIL rand%0d_txn_count: got %0d expected %0d", it, got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i])
          $display("[TB] FAIL rand%0d_txn%0d: got %h expected %h", it, i, got_q[i], exp_q[i]);
        else n_pass++;
      end
      n_checks++;
      if (done_cyc !== c0 + exp_lat)
        $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", it, done_cyc - c0, exp_lat);
      else n_pass++;
      n_checks++;
      if (proto_errs !== 0 || done_cycles !== 1 || busy_cycles !== done_cyc - c0)
        $display("[TB] FAIL rand%0d_protocol: got errs=%0d done=%0d busy=%0d expected 0/1/%0d",
                 it, proto_errs, done_cycles, busy_cycles, done_cyc - c0);
      else n_pass++;
    end
    stall_pct = 0;
  endtask

  task automatic test_reset_mid_poll();
    bool_loop: begin end
    stall_pct = 0; zeros_left = 1000; lock_d = 0; poll_ok_cyc = -1;
    cfg_m = 18'h11111; cfg_n = 18'h22222; cfg_c = CW'(36'h333334444); cfg_start = 1'b1;
    for (int i = 0; i < 100 && !mgmt_read; i++) step();
    n_checks++;
    if (mgmt_read !== 1'b1)
      $display("[TB] FAIL rstpoll_reach_poll: got read=%b expected 1", mgmt_read);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({cfg_busy, cfg_done, cfg_err, mgmt_address, mgmt_write, mgmt_read, mgmt_writedata} !== '0)
      $display("[TB] FAIL rstpoll_outputs: got %h expected 0",
               {cfg_busy, cfg_done, cfg_err, mgmt_address, mgmt_write, mgmt_read, mgmt_writedata});
    else n_pass++;
    step();
    rst = 1'b0;
    zeros_left = 0;
    run_cfg(18'h0ABCD, 18'h1F00F, {18'h2AAAA, 18'h15555});
    build_expected(18'h0ABCD, 18'h1F00F, {18'h2AAAA, 18'h15555}, 1);
    n_checks++;
    if (got_q.size() !== exp_q.size() || got_q[0] !== exp_q[0])
      $display("[TB] FAIL rstpoll_restart: got count=%0d first=%h expected count=%0d first=%h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : txn_t'(0), exp_q.size(), exp_q[0]);
    else n_pass++;
    n_checks++;
    if (done_cyc !== c0 + 6 + NUM_C + LG)
      $display("[TB] FAIL rstpoll_latency: got %0d expected %0d", done_cyc - c0, 6 + NUM_C + LG);
    else n_pass++;
  endtask

`ifdef PLL_RECONFIG_LOCK_TIMEOUT_EN
  task automatic test_lock_timeout();
    stall_pct = 0; zeros_left = 0; lock_d = 0; lock_never = 1'b1;
    run_cfg(18'h01212, 18'h20302, {18'h00F0F, 18'h01E1E});
    n_checks++;
    if (done_cyc !== c0 + 5 + NUM_C + LG + LT || done_cycles !== 1)
      $display("[TB] FAIL timeout_latency: got %0d done=%0d expected %0d done=1",
               done_cyc - c0, done_cycles, 5 + NUM_C + LG + LT);
    else n_pass++;
    n_checks++;
    if (cfg_err !== 1'b1)
      $display("[TB] FAIL timeout_err_set: got %b expected 1", cfg_err);
    else n_pass++;
    lock_never = 1'b0;
    run_cfg(18'h01212, 18'h20302, {18'h00F0F, 18'h01E1E});
    n_checks++;
    if (cfg_err !== 1'b0)
      $display("[TB] FAIL timeout_err_clear: got %b expected 0", cfg_err);
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_m = '0; cfg_n = '0; cfg_c = '0;
    mgmt_readdata = '0; mgmt_waitrequest = 1'b0; pll_locked = 1'b0;
    stall_pct = 0; stall_addr = -1; stall_left = 0; zeros_left = 0; lock_d = 0;
    lock_never = 1'b0; glitch_start = 1'b0; poll_ok_cyc = -1; done_cyc = -1;
    prev_stalled = 1'b0; prev_bus = '0; proto_errs = 0;
    test_reset();
    test_directed();
    test_waitrequest();
    test_poll_retry();
    test_ignored_start();
    test_random();
    test_reset_mid_poll();
`ifdef PLL_RECONFIG_LOCK_TIMEOUT_EN
    test_lock_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
